flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum WAIT-state cycles before a transaction is aborted.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum 1: idle cycles enforced between transactions (flash CS high time).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports p0_req in 1, p0_addr in 24: port 0 (instruction fetch) read request and byte address.
REQ-006 SHALL have ports p0_ack out 1, p0_done out 1: port 0 accepted and completed pulses.
REQ-007 SHALL have ports p1_req in 1, p1_write in 1, p1_addr in 24, p1_wdata in 32: port 1 (data) request, 1 = write, address, write data.
REQ-008 SHALL have ports p1_ack out 1, p1_done out 1: port 1 accepted and completed pulses.
REQ-009 SHALL have ports rsp_data out 32, rsp_err out 1: response shared by both ports, valid only in a pX_done cycle.
REQ-010 SHALL have ports flash_en out 1, flash_write out 1, flash_addr out 24, flash_wdata out 32: SPI flash controller command.
REQ-011 SHALL have ports flash_rdata in 32, flash_ready in 1: flash controller read data and completion strobe.
REQ-012 SHALL have port busy out 1: high in every state other than IDLE.

Function
REQ-013 SHALL implement a state machine with states IDLE, WAIT and GAP; all outputs SHALL be registered.
REQ-014 In IDLE, a sampled request SHALL cause a grant; with both requests high, the port that did not win the last grant SHALL win (round-robin); a single request SHALL always be granted.
REQ-015 On grant, the request fields SHALL be latched. In the following cycle, pX_ack SHALL be high for exactly one cycle, flash_en SHALL rise, and the state SHALL be WAIT.
REQ-016 Port 0 transactions SHALL drive flash_write=0. Port 1 SHALL drive flash_write=p1_write and flash_wdata=p1_wdata, both as latched.
REQ-017 Requesters may drop or change req/addr/wdata after ack; the arbiter SHALL NOT re-sample them until the next IDLE.
REQ-018 In WAIT, flash_en, flash_write, flash_addr and flash_wdata SHALL remain stable until flash_ready is sampled high.
REQ-019 When flash_ready is sampled high in WAIT, the next cycle SHALL have: flash_en=0, the owner's pX_done=1 for one cycle, and rsp_err=0. rsp_data SHALL be flash_rdata for a read and 0 for a write. The state SHALL become GAP.
REQ-020 A 17-bit WAIT counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES without flash_ready, the arbiter SHALL act as in REQ-019, with rsp_err=1 and rsp_data=0.
REQ-021 If flash_ready and the timeout occur in the same cycle, flash_ready SHALL win (rsp_err=0).
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, the done cycle counting as the first, then return to IDLE. flash_en SHALL therefore stay low for at least GAP_CYCLES+1 cycles between transactions.
REQ-023 flash_ready seen in IDLE or GAP SHALL be ignored: no done pulse and no state change.
REQ-024 ack and done SHALL never be high for both ports in the same cycle. Exactly one done SHALL follow each ack.
REQ-025 Outside done cycles, rsp_data and rsp_err SHALL hold their last values.

Reset
REQ-026 While reset_n=0 at a clock edge, the state SHALL go to IDLE, and all outputs (flash_en, flash_write, flash_addr, flash_wdata, acks, dones, rsp_data, rsp_err, busy) SHALL be 0 from the next cycle.
REQ-027 Reset SHALL set last-grant to port 1, so port 0 wins the first tie.
REQ-028 Reset in WAIT SHALL abandon the transaction without any done pulse. flash_en SHALL fall in the cycle after the reset edge.

Verification
REQ-029 Single read: p0_req with p0_addr=0x123456, flash_ready 5 cycles after flash_en with flash_rdata=0xDEADBEEF -> p0_ack one cycle after the request; flash_addr=0x123456; p0_done with rsp_data=0xDEADBEEF, rsp_err=0.
REQ-030 Tie: p0_req and p1_req held continuously for 4 transactions -> grant order p0, p1, p0, p1; no overlapping acks; flash_en low at least GAP_CYCLES+1 cycles between transactions.
REQ-031 Write: p1_write=1, p1_addr=0x0F0F0F, p1_wdata=0xA5A5A5A5 -> flash_write=1 and fields stable until flash_ready; p1_done with rsp_data=0.
REQ-032 Timeout: TIMEOUT_CYCLES=16, flash_ready never asserted -> p0_done exactly 17 cycles after flash_en rises, rsp_err=1, rsp_data=0, then normal service resumes.
REQ-033 Timeout race: flash_ready asserted in the cycle the counter hits 16 -> rsp_err=0 and rsp_data=flash_rdata.
REQ-034 Reset mid-WAIT, plus stray flash_ready in GAP -> reset: flash_en=0 next cycle, no done, next tie granted to p0; stray flash_ready: no done pulse, no state change.

Source files
------------

// File: rtl/flash_arbiter_if.sv
// rtl/flash_arbiter_if.sv - requester, response and flash command signals of the flash arbiter
interface flash_arbiter_if;
    logic        p0_req;
    logic [23:0] p0_addr;
    logic        p0_ack;
    logic        p0_done;
    logic        p1_req;
    logic        p1_write;
    logic [23:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_done;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flash_en;
    logic        flash_write;
    logic [23:0] flash_addr;
    logic [31:0] flash_wdata;
    logic [31:0] flash_rdata;
    logic        flash_ready;
    logic        busy;

    // Arbiter side
    modport slave (
        input  p0_req, p0_addr, p1_req, p1_write, p1_addr, p1_wdata, flash_rdata, flash_ready,
        output p0_ack, p0_done, p1_ack, p1_done, rsp_data, rsp_err,
        output flash_en, flash_write, flash_addr, flash_wdata, busy
    );

    // Requesters and flash controller side
    modport master (
        output p0_req, p0_addr, p1_req, p1_write, p1_addr, p1_wdata, flash_rdata, flash_ready,
        input  p0_ack, p0_done, p1_ack, p1_done, rsp_data, rsp_err,
        input  flash_en, flash_write, flash_addr, flash_wdata, busy
    );
endinterface

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - two-port round-robin arbiter in front of an SPI flash controller
module flash_arbiter #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    flash_arbiter_if.slave  bus
);
    localparam logic [16:0] TO_LIMIT  = 17'(TIMEOUT_CYCLES);
    localparam int          GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_owner;
    logic [16:0]   r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_ack0, r_ack1, r_done0, r_done1;
    logic          r_en, r_write, r_rsp_err, r_busy;
    logic [23:0]   r_addr;
    logic [31:0]   r_wdata, r_rsp_data;

    // Port 1 wins when it asks alone, or on a tie when port 0 had the last grant
    wire w_pick1   = bus.p1_req && (!bus.p0_req || !r_last);
    wire w_any     = bus.p0_req || bus.p1_req;
    wire w_timeout = (r_cnt == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_en       <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick1;
                        r_last  <= w_pick1;
                        r_ack0  <= !w_pick1;
                        r_ack1  <= w_pick1;
                        r_en    <= 1'b1;
                        r_write <= w_pick1 && bus.p1_write;
                        r_addr  <= w_pick1 ? bus.p1_addr : bus.p0_addr;
                        r_wdata <= w_pick1 ? bus.p1_wdata : 32'd0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // flash_ready takes precedence over a coincident timeout
                    if (bus.flash_ready || w_timeout) begin
                        r_en       <= 1'b0;
                        r_done0    <= !r_owner;
                        r_done1    <= r_owner;
                        r_rsp_err  <= !bus.flash_ready;
                        r_rsp_data <= (bus.flash_ready && !r_write) ? bus.flash_rdata : 32'd0;
                        r_gap      <= GW'(1);
                        r_state    <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap >= GAP_LIMIT) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_ack      = r_ack0;
    assign bus.p1_ack      = r_ack1;
    assign bus.p0_done     = r_done0;
    assign bus.p1_done     = r_done1;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.flash_en    = r_en;
    assign bus.flash_write = r_write;
    assign bus.flash_addr  = r_addr;
    assign bus.flash_wdata = r_wdata;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - directed and randomized check of flash_arbiter against a timestamp model
module tb_flash_arbiter;
    localparam int TO  = 16;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    flash_arbiter_if bus();

    flash_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Model: a transaction in flight is an owner plus its grant edge; idle time is an earliest-grant edge
    int          m_owner = -1;
    int          m_start = 0;
    int          m_free  = 0;
    int          m_last  = 1;
    int          m_delay = 0;
    logic        m_write = 1'b0;
    logic        e_ack0 = 0, e_ack1 = 0, e_done0 = 0, e_done1 = 0;
    logic        e_en = 0, e_write = 0, e_rsp_err = 0, e_busy = 0;
    logic [23:0] e_addr = '0;
    logic [31:0] e_wdata = '0, e_rsp_data = '0;

    int          fix_delay = 0;
    bit          stray_en  = 1'b0;
    bit          use_fix_rd = 1'b0;
    logic [31:0] fix_rdata = 32'hDEADBEEF;
    int          ack_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_step();
        int win;
        e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0;
        if (!reset_n) begin
            m_owner = -1; m_last = 1; m_free = edge_n + 1;
            e_en = 0; e_write = 0; e_addr = '0; e_wdata = '0;
            e_rsp_data = '0; e_rsp_err = 0;
        end else if (m_owner >= 0) begin
            if (bus.flash_ready || (edge_n - m_start == TO + 1)) begin
                if (m_owner == 0) e_done0 = 1; else e_done1 = 1;
                e_rsp_err  = !bus.flash_ready;
                e_rsp_data = (bus.flash_ready && !m_write) ? bus.flash_rdata : 32'd0;
                e_en = 0;
                m_owner = -1;
                m_free = edge_n + GAP + 1;
            end
        end else if (edge_n >= m_free && (bus.p0_req || bus.p1_req)) begin
            if (bus.p0_req && bus.p1_req) win = 1 - m_last;
            else win = bus.p1_req ? 1 : 0;
            m_owner = win; m_last = win; m_start = edge_n;
            e_en = 1;
            if (win == 0) e_ack0 = 1; else e_ack1 = 1;
            m_write = (win == 1) && bus.p1_write;
            e_write = m_write;
            e_addr  = (win == 1) ? bus.p1_addr : bus.p0_addr;
            e_wdata = bus.p1_wdata;
            m_delay = (fix_delay == 0) ? int'($urandom_range(1, TO + 4)) : fix_delay;
        end
        e_busy = (m_owner >= 0) || (edge_n + 1 < m_free);
    endtask

    task automatic check_outputs();
        chk("p0_ack",   bus.p0_ack,   e_ack0);
        chk("p1_ack",   bus.p1_ack,   e_ack1);
        chk("p0_done",  bus.p0_done,  e_done0);
        chk("p1_done",  bus.p1_done,  e_done1);
        chk("flash_en", bus.flash_en, e_en);
        chk("busy",     bus.busy,     e_busy);
        chk("rsp_data", bus.rsp_data, e_rsp_data);
        chk("rsp_err",  bus.rsp_err,  e_rsp_err);
        if (e_en) begin
            chk("flash_addr",  bus.flash_addr,  e_addr);
            chk("flash_write", bus.flash_write, e_write);
            if (m_owner == 1) chk("flash_wdata", bus.flash_wdata, e_wdata);
        end
        if (bus.p0_ack) ack_log.push_back(0);
        if (bus.p1_ack) ack_log.push_back(1);
    endtask

    task automatic tick();
        if (m_owner >= 0) bus.flash_ready = (m_delay > 0) && (edge_n + 1 - m_start == m_delay);
        else bus.flash_ready = stray_en && ($urandom_range(0, 3) == 0);
        bus.flash_rdata = use_fix_rd ? fix_rdata : $urandom();
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input logic r0, input logic r1, input logic wr,
                           input logic [23:0] a0, input logic [23:0] a1, input logic [31:0] wd);
        bus.p0_req = r0; bus.p1_req = r1; bus.p1_write = wr;
        bus.p0_addr = a0; bus.p1_addr = a1; bus.p1_wdata = wd;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    initial begin
        set_req(0, 0, 0, '0, '0, '0);
        bus.flash_ready = 1'b0;
        bus.flash_rdata = '0;
        do_reset();
        ticks(2);

        // Single read
        use_fix_rd = 1'b1; fix_delay = 5;
        set_req(1, 0, 0, 24'h123456, '0, '0);
        tick();
        set_req(0, 0, 0, 24'h000000, '0, '0);
        ticks(10);
        chk("read_rsp_data", bus.rsp_data, 32'hDEADBEEF);
        use_fix_rd = 1'b0;

        // Tie after reset: p0 first, then strict alternation
        do_reset();
        ack_log.delete();
        fix_delay = 3;
        set_req(1, 1, 0, 24'h000100, 24'h000200, 32'h11112222);
        for (int i = 0; i < 200 && ack_log.size() < 4; i++) tick();
        chk("tie_ack_count", ack_log.size(), 4);
        if (ack_log.size() >= 4) begin
            chk("tie_order0", ack_log[0], 0);
            chk("tie_order1", ack_log[1], 1);
            chk("tie_order2", ack_log[2], 0);
            chk("tie_order3", ack_log[3], 1);
        end
        set_req(0, 0, 0, '0, '0, '0);
        ticks(12);

        // Write, then timeout, then timeout race against flash_ready
        fix_delay = 6;
        set_req(0, 1, 1, '0, 24'h0F0F0F, 32'hA5A5A5A5);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        ticks(12);
        fix_delay = -1;
        set_req(1, 0, 0, 24'h00ABCD, '0, '0);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        ticks(22);
        chk("timeout_err", bus.rsp_err, 1);
        fix_delay = 17;
        set_req(1, 0, 0, 24'h00BEEF, '0, '0);
        tick();
        set_req(0, 0, 0, '0, '0, '0);
        ticks(22);
        chk("race_err", bus.rsp_err, 0);

        // Reset mid-WAIT, then stray flash_ready while idle
        fix_delay = -1;
        set_req(1, 1, 0, 24'h000300, 24'h000400, 32'h0);
        ticks(5);
        do_reset();
        fix_delay = 2;
        ticks(10);
        set_req(0, 0, 0, '0, '0, '0);
        stray_en = 1'b1;
        ticks(20);

        // Randomized traffic with stray strobes and occasional reset
        fix_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    24'($urandom()), 24'($urandom()), $urandom());
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset_n = 1'b1;
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
